// File: rtl/four_one_mux_pkg.sv
// rtl/four_one_mux_pkg.sv - shared constants, FSM state type and one-hot helper for the 4:1 stream mux
package four_one_mux_pkg;

  localparam int CH_N  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  // 2-to-4 one-hot decode of a channel index
  function automatic logic [CH_N-1:0] onehot2(input logic [SEL_W-1:0] sel);
    logic [CH_N-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - combinational 4-way round-robin picker starting the scan at ptr
module rr_arbiter_4
  import four_one_mux_pkg::*;
(
  input  logic [CH_N-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [CH_N-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic             w_found;
  logic [SEL_W-1:0] w_idx;

  // scan ptr, ptr+1, ... (mod 4); first requester wins, no requester yields an all-zero grant
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < CH_N; k++) begin
      w_idx = ptr + SEL_W'(k);
      if (!w_found && req[w_idx]) begin
        w_found   = 1'b1;
        grant     = onehot2(w_idx);
        grant_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/four_one_stream_mux_rr.sv
// rtl/four_one_stream_mux_rr.sv - packet-aware round-robin 4:1 stream collector with one registered output stage
module four_one_stream_mux_rr
  import four_one_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_N-1:0]          in_valid,
  input  logic [CH_N*DATA_W-1:0]   in_data,
  input  logic [CH_N-1:0]          in_last,
  output logic [CH_N-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [SEL_W-1:0]   r_lock_ch;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_last;
  logic [SEL_W-1:0]   r_out_sel;

  logic [CH_N-1:0]    w_arb_grant;
  logic [SEL_W-1:0]   w_arb_idx;
  logic [CH_N-1:0]    w_grant;
  logic [SEL_W-1:0]   w_grant_idx;
  logic               w_load_ok;
  logic [CH_N-1:0]    w_in_ready;
  logic               w_xfer;
  logic               w_xfer_last;
  logic [DATA_W-1:0]  w_sel_data;

  rr_arbiter_4 u_arb (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_arb_grant),
    .grant_idx (w_arb_idx)
  );

  // register may take a new beat whenever it is empty or being drained this cycle
  assign w_load_ok   = !r_out_valid | out_ready;
  // reset gating keeps every channel stalled while rst_n is low, independent of the clock
  assign w_in_ready  = rst_n ? ({CH_N{w_load_ok}} & w_grant) : '0;
  assign in_ready    = w_in_ready;
  assign w_xfer      = |(in_valid & w_in_ready);
  assign w_xfer_last = in_last[w_grant_idx];
  assign w_sel_data  = in_data[int'(w_grant_idx)*DATA_W +: DATA_W];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a non-last beat opens a packet, the last beat closes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:     if (w_xfer && !w_xfer_last) w_state_nxt = LOCK;
      LOCK:    if (w_xfer && w_xfer_last)  w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // FSM outputs: the open packet's channel owns the grant until its last beat
  always_comb begin
    w_grant     = w_arb_grant;
    w_grant_idx = w_arb_idx;
    if (r_state == LOCK) begin
      w_grant     = onehot2(r_lock_ch);
      w_grant_idx = r_lock_ch;
    end
  end

  // pointer advances past the channel that finished a packet; lock channel captured on packet open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      if (w_xfer_last) begin
        r_rr_ptr <= w_grant_idx + SEL_W'(1);
      end else if (r_state == ARB) begin
        r_lock_ch <= w_grant_idx;
      end
    end
  end

  // output stage: load on transfer, clear valid on drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_xfer_last;
      r_out_sel   <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_four_one_stream_mux_rr.sv
// tb/tb_four_one_stream_mux_rr.sv - directed and random checks of the 4:1 stream mux against a behavioural model
module tb_four_one_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;

  four_one_stream_mux_rr #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: pointer as an integer, open packet channel (-1 = none), one-entry output slot
  int         m_ptr;
  int         m_lock;
  logic       m_ov;
  logic [7:0] m_od;
  logic       m_ol;
  logic [1:0] m_os;

  // beats accepted downstream, in order
  int lg_sel[$];
  int lg_data[$];
  int lg_last[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lock = -1;
    m_ov   = 1'b0;
    m_od   = 8'h00;
    m_ol   = 1'b0;
    m_os   = 2'd0;
  endtask

  // one clock cycle: drive inputs, compare DUT against the model, then advance the model
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic ordy);
    int   g;
    bit   has;
    bit   load_ok;
    logic [3:0] exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      chk("out_data", {24'd0, out_data}, {24'd0, m_od});
      chk("out_last", {31'd0, out_last}, {31'd0, m_ol});
      chk("out_sel",  {30'd0, out_sel},  {30'd0, m_os});
    end
    has = 1'b0;
    g   = 0;
    if (m_lock >= 0) begin
      has = 1'b1;
      g   = m_lock;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!has && v[(m_ptr + k) % 4]) begin
          has = 1'b1;
          g   = (m_ptr + k) % 4;
        end
      end
    end
    load_ok = !m_ov || ordy;
    exp_rdy = (load_ok && has) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    if (out_valid && out_ready) begin
      lg_sel.push_back(int'(out_sel));
      lg_data.push_back(int'(out_data));
      lg_last.push_back(int'(out_last));
    end
    if (has && exp_rdy[g] && v[g]) begin
      m_ov = 1'b1;
      m_od = d[g*8 +: 8];
      m_ol = l[g];
      m_os = 2'(g);
      if (l[g]) begin
        m_ptr  = (g + 1) % 4;
        m_lock = -1;
      end else begin
        m_lock = g;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input int sel, input int data, input int last);
    chk({tag, "_present"}, {31'd0, (lg_sel.size() > idx)}, 32'd1);
    if (lg_sel.size() > idx) begin
      chk({tag, "_sel"},  lg_sel[idx],  sel);
      chk({tag, "_data"}, lg_data[idx], data);
      chk({tag, "_last"}, lg_last[idx], last);
    end
  endtask

  initial begin
    int base;
    int rr_sel[8];
    int rr_data[8];
    int pk_sel[6];
    int pk_data[6];
    int pk_last[6];
    logic [3:0] rv;
    logic [3:0] rl;

    // reset held from time zero with requests present
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    in_data   = 32'h13121110;
    out_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {28'd0, in_ready},  32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_sel",   {30'd0, out_sel},   32'd0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 4'h0;
    rst_n    = 1'b1;
    repeat (3) step(4'h0, 4'h0, 32'h0, 1'b1);

    // round-robin fairness, single-beat packets, full throughput
    base = lg_sel.size();
    repeat (8) step(4'hF, 4'hF, 32'h13121110, 1'b1);
    step(4'h0, 4'h0, 32'h0, 1'b1);
    chk("rr_beats", lg_sel.size() - base, 8);
    rr_sel  = '{0, 1, 2, 3, 0, 1, 2, 3};
    rr_data = '{'h10, 'h11, 'h12, 'h13, 'h10, 'h11, 'h12, 'h13};
    for (int i = 0; i < 8; i++) chk_log("rr", base + i, rr_sel[i], rr_data[i], 1);

    // packet lock on ch2 while the others keep requesting
    base = lg_sel.size();
    step(4'b0010, 4'b0010, 32'h00003100, 1'b1);
    step(4'hF, 4'b1011, 32'h43A04140, 1'b1);
    step(4'hF, 4'b1011, 32'h43A14140, 1'b1);
    step(4'hF, 4'hF,    32'h43A24140, 1'b1);
    step(4'hF, 4'hF,    32'h43A24140, 1'b1);
    step(4'hF, 4'hF,    32'h43A24140, 1'b1);
    step(4'h0, 4'h0, 32'h0, 1'b1);
    pk_sel  = '{1, 2, 2, 2, 3, 0};
    pk_data = '{'h31, 'hA0, 'hA1, 'hA2, 'h43, 'h40};
    pk_last = '{1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) chk_log("lock", base + i, pk_sel[i], pk_data[i], pk_last[i]);

    // backpressure on ch1: beat held, no acceptance, then drain and load together
    step(4'b0010, 4'b0010, 32'h00002100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 4'b0010, 32'h00002200, 1'b0);
      chk("bp_in_ready", {28'd0, in_ready}, 32'd0);
      chk("bp_hold",     {24'd0, out_data}, 32'h21);
    end
    step(4'b0010, 4'b0010, 32'h00002200, 1'b1);
    chk("bp_drain_load_rdy", {28'd0, in_ready}, 32'b0010);
    step(4'h0, 4'h0, 32'h0, 1'b1);
    chk("bp_next_data", {24'd0, out_data}, 32'h22);
    step(4'h0, 4'h0, 32'h0, 1'b1);

    // pointer wrap 3 -> 0 and sparse requests
    base = lg_sel.size();
    step(4'b0100, 4'b0100, 32'h00520000, 1'b1);
    step(4'b0010, 4'b0010, 32'h00005100, 1'b1);
    chk("wrap_ch1_rdy", {28'd0, in_ready}, 32'b0010);
    step(4'b1010, 4'b1010, 32'h63006100, 1'b1);
    chk("wrap_ch3_first", {28'd0, in_ready}, 32'b1000);
    step(4'b1010, 4'b1010, 32'h63006100, 1'b1);
    step(4'h0, 4'h0, 32'h0, 1'b1);
    chk_log("wrap0", base + 0, 2, 'h52, 1);
    chk_log("wrap1", base + 1, 1, 'h51, 1);
    chk_log("wrap2", base + 2, 3, 'h63, 1);
    chk_log("wrap3", base + 3, 1, 'h61, 1);

    // lock stall: ch0 bubble must not let ch1 in
    base = lg_sel.size();
    step(4'b0001, 4'b0000, 32'h00000070, 1'b1);
    repeat (2) begin
      step(4'b0010, 4'b0010, 32'h00008100, 1'b1);
      chk("stall_ch1_rdy", {31'd0, in_ready[1]}, 32'd0);
    end
    step(4'b0011, 4'b0011, 32'h00008171, 1'b1);
    step(4'b0010, 4'b0010, 32'h00008100, 1'b1);
    step(4'h0, 4'h0, 32'h0, 1'b1);
    chk_log("stall0", base + 0, 0, 'h70, 0);
    chk_log("stall1", base + 1, 0, 'h71, 1);
    chk_log("stall2", base + 2, 1, 'h81, 1);

    // reset mid-packet with a held beat: clears immediately and drops the lock
    step(4'b1000, 4'b0000, 32'h90000000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {28'd0, in_ready},  32'd0);
    chk("mid_rst_out_sel",   {30'd0, out_sel},   32'd0);
    in_valid = 4'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1001, 4'b1001, 32'h93000080, 1'b1);
    chk("post_rst_ch0", {28'd0, in_ready}, 32'b0001);
    step(4'h0, 4'h0, 32'h0, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rv = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) rl[b] = ($urandom_range(0, 9) < 4);
      step(rv, rl, $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
